// File: rtl/gf2m_pkg.sv
// Shared GF(2^m) field definition, used by the point-arithmetic FSMs and the multiplier datapath.
package gf2m_pkg;

  localparam int FIELD_M = 163;
  localparam logic [FIELD_M-1:0] FIELD_POLY = 163'hC9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mul_state_t;

  // Width of a down-counter that must hold m-1; at least one bit.
  function automatic int cnt_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/gf2m_serial_mul_if.sv
// Request/response handshake between a point-arithmetic FSM (master) and the field multiplier (slave).
interface gf2m_serial_mul_if
  import gf2m_pkg::*;
#(
  parameter int M = FIELD_M
);

  logic         MUL_IN_VALID;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic         MUL_OUT_VALID;
  logic [M-1:0] P;
  logic         ERROR;
  logic         BUSY;

  modport master (
    output MUL_IN_VALID, A, B,
    input  MUL_OUT_VALID, P, ERROR, BUSY
  );

  modport slave (
    input  MUL_IN_VALID, A, B,
    output MUL_OUT_VALID, P, ERROR, BUSY
  );

endinterface

// File: rtl/gf2m_mul_step.sv
// One MSB-first iteration of polynomial-basis multiplication: c_next = (c*x mod f) + b_bit*a.
module gf2m_mul_step
  import gf2m_pkg::*;
#(
  parameter int           M    = FIELD_M,
  parameter logic [M-1:0] POLY = FIELD_POLY[M-1:0]
) (
  input  logic [M-1:0] c,
  input  logic [M-1:0] a,
  input  logic         b_bit,
  output logic [M-1:0] c_next
);

  logic [M-1:0] c_sh;

  // x^M overflows out of the top bit and folds back in as POLY.
  assign c_sh   = {c[M-2:0], 1'b0} ^ (c[M-1] ? POLY : '0);
  assign c_next = c_sh ^ (b_bit ? a : '0);

endmodule

// File: rtl/gf2m_serial_mul.sv
// Bit-serial GF(2^M) multiplier: M cycles per product, scanning B from its MSB.
//   state   | meaning
//   ST_IDLE | waiting for MUL_IN_VALID; P holds the last product
//   ST_RUN  | one multiply step per cycle, cnt counts down to 0
module gf2m_serial_mul
  import gf2m_pkg::*;
#(
  parameter int           M    = FIELD_M,
  parameter logic [M-1:0] POLY = FIELD_POLY[M-1:0]
) (
  input  logic             CLK,
  input  logic             RST_N,
  gf2m_serial_mul_if.slave bus
);

  localparam int CW = cnt_width(M);

  mul_state_t    state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  c_r;
  logic [M-1:0]  a_r;
  logic [M-1:0]  b_r;
  logic [M-1:0]  c_next;
  logic [M-1:0]  p_r;
  logic          out_valid_r;
  logic          error_r;
  logic          busy_r;

  gf2m_mul_step #(
    .M    (M),
    .POLY (POLY)
  ) u_step (
    .c      (c_r),
    .a      (a_r),
    .b_bit  (b_r[cnt]),
    .c_next (c_next)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      c_r         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      p_r         <= '0;
      out_valid_r <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid_r <= 1'b0;
          if (bus.MUL_IN_VALID) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            c_r     <= '0;
            cnt     <= CW'(M - 1);
            busy_r  <= 1'b1;
            error_r <= 1'b0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A request while busy, including on the final step, is dropped and flagged.
          if (bus.MUL_IN_VALID) begin
            error_r <= 1'b1;
          end
          c_r <= c_next;
          if (cnt == '0) begin
            p_r         <= c_next;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MUL_OUT_VALID = out_valid_r;
  assign bus.P             = p_r;
  assign bus.ERROR         = error_r;
  assign bus.BUSY          = busy_r;

endmodule

// File: doc/gf2m_serial_mul.md
Name: gf2m_serial_mul

Overview:
- Bit-serial GF(2^M) multiplier in polynomial basis. It is the responder side of the MUL_IN_VALID / MUL_OUT_VALID / ERROR handshake that the point-arithmetic control FSMs (doubling, addition) use as initiators.
- It captures two operands on a request pulse, computes A·B mod f(x) MSB-first over M cycles, then returns the product with a one-cycle valid pulse.
- It flags protocol violations on ERROR.

Parameters:
- M, 163, field degree and operand/product width.
- POLY, 163'hC9, low M bits of the reduction polynomial f(x) = x^M + POLY. Default is x^163+x^7+x^6+x^3+1.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, synchronous, active-low
- MUL_IN_VALID  in  1  request pulse, one cycle wide; A and B are valid in the same cycle
- A  in  M  multiplicand
- B  in  M  multiplier, scanned MSB first
- MUL_OUT_VALID  out  1  one-cycle pulse; P is valid in this cycle and holds afterwards
- P  out  M  product A·B mod f(x)
- ERROR  out  1  sticky protocol-violation flag
- BUSY  out  1  high while a multiplication is in progress

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - state=IDLE, cnt=0, C=0, a_r=0, b_r=0.
  - P=0, MUL_OUT_VALID=0, ERROR=0, BUSY=0.
  - Reset mid-operation aborts the operation; no MUL_OUT_VALID pulse is produced for it.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - MUL_OUT_VALID <= 0.
  - If MUL_IN_VALID=1: a_r <= A, b_r <= B, C <= 0, cnt <= M-1, BUSY <= 1, ERROR <= 0, go to RUN.
- RUN, one iteration per cycle:
  - C' = (C<<1 mod f) XOR (b_r[cnt] ? a_r : 0).
  - Reduction: if C[M-1]=1, then C<<1 drops that bit and XORs in POLY.
  - cnt decrements each cycle.
  - When cnt==0: P <= C', MUL_OUT_VALID <= 1, BUSY <= 0, go to IDLE.
- Latency: request sampled at edge k produces MUL_OUT_VALID high in the cycle after edge k+M. Exactly M RUN cycles.
- Throughput: a new request may be sampled in the same cycle MUL_OUT_VALID is high (state is already IDLE). Back-to-back issue interval is therefore M+1 cycles.
- MUL_IN_VALID while in RUN:
  - The request is ignored and the current operation continues undisturbed.
  - ERROR <= 1 and stays high until the next accepted request or reset.
  - This includes a request held high for more than one cycle.
- MUL_IN_VALID in the same cycle as the final RUN iteration: treated as in RUN, so ERROR is set and the request is ignored.
- P holds its value until the next completion; it is not cleared at the start of a new request.
- A or B equal to 0 yields P=0. A=1 yields P=B (operands are < 2^M by width, so no range check is needed).
- cnt width is clog2(M).
- No combinational path from any input to any output.

Decomposition:
- Shared package gf2m_pkg:
  - localparams FIELD_M=163 and FIELD_POLY=163'hC9, so that the point FSMs and datapath registers use one definition.
  - Width helper for cnt.
- Sub-module gf2m_mul_step:
  - Purely combinational; inputs (c, a, bit), output next c.
  - Parameterised by M and POLY.
  - Instantiated once in the RUN datapath; reusable for a future digit-serial variant.

Test Plan:
- M=4, POLY=4'b0011: A=4'h3, B=4'h5 pulse → after exactly 4 cycles MUL_OUT_VALID=1 for 1 cycle, P=4'hF, ERROR=0, BUSY high for the 4 cycles.
- M=4: A=4'h8, B=4'h2 → P=4'h3 (x^4 reduced to x+1). Then A=4'hF, B=4'hF → P=4'hA.
- Default M=163:
  - A=1, B=random → P=B.
  - A=random, B=0 → P=0.
  - 200 random pairs checked against a software reference model.
- Back-to-back: a second request issued in the MUL_OUT_VALID cycle is accepted; two pulses arrive M+1 cycles apart, both results correct.
- Protocol violation: MUL_IN_VALID held for 2 cycles → ERROR=1 from the next cycle; the first operands' product is still correct; ERROR clears on the next accepted request.
- RST_N=0 for 1 cycle at RUN cycle 2 → no MUL_OUT_VALID; P=0, BUSY=0, ERROR=0; a subsequent request completes normally.
